// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : state encodings, NOP constant and slot type for the fetch unit
// Revision  : 1.0
// ============================================================================
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_KILL  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSN = 32'h00000013;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
    logic        access_fault;
    logic        addr_misaligned;
  } fetch_slot_t;

  function automatic fetch_slot_t make_slot(input logic [31:0] insn, input logic [31:0] pc,
                                            input logic af, input logic mf);
    fetch_slot_t s;
    s.insn            = insn;
    s.pc              = pc;
    s.access_fault    = af;
    s.addr_misaligned = mf;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
// fetch : single-outstanding Wishbone instruction fetch with one-entry buffer
// Revision : 1.0
// ============================================================================
module fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h80000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] iwbm_addr_o,
  output logic        iwbm_cyc_o,
  output logic        iwbm_stb_o,
  input  logic [31:0] iwbm_dat_i,
  input  logic        iwbm_ack_i,
  input  logic        iwbm_err_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        e_inst_access_fault_o,
  output logic        e_inst_addr_misaligned_o
);
  import fetch_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  fetch_slot_t  slot_q, slot_d;
  logic         pc_misaligned;
  logic         bus_done;
  logic         bus_busy;

  // A misaligned pc reaching REQ never starts a bus cycle; it faults instead.
  assign pc_misaligned = (pc_q[1:0] != 2'b00);
  assign iwbm_cyc_o    = ((state_q == ST_REQ) && !pc_misaligned) || (state_q == ST_KILL);
  assign iwbm_stb_o    = iwbm_cyc_o;
  assign iwbm_addr_o   = {addr_q[31:2], 2'b00};
  assign bus_done      = iwbm_cyc_o && (iwbm_ack_i || iwbm_err_i);
  assign bus_busy      = iwbm_cyc_o && !bus_done;

  assign valid_o                  = (state_q == ST_DRAIN);
  assign instruction_o            = slot_q.insn;
  assign pc_o                     = slot_q.pc;
  assign e_inst_access_fault_o    = slot_q.access_fault;
  assign e_inst_addr_misaligned_o = slot_q.addr_misaligned;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    slot_d  = slot_q;
    if (branch_taken_i) begin
      pc_d = branch_target_i;
      // An open bus cycle must still finish; its response is dropped in KILL.
      if (bus_busy) begin
        state_d = ST_KILL;
      end else if (branch_target_i[1:0] != 2'b00) begin
        slot_d  = make_slot(NOP_INSN, branch_target_i, 1'b0, 1'b1);
        state_d = ST_DRAIN;
      end else begin
        addr_d  = branch_target_i;
        state_d = ST_REQ;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          addr_d  = pc_q;
          state_d = ST_REQ;
        end
        ST_REQ: begin
          if (pc_misaligned) begin
            slot_d  = make_slot(NOP_INSN, pc_q, 1'b0, 1'b1);
            state_d = ST_DRAIN;
          end else if (iwbm_ack_i) begin
            slot_d  = make_slot(iwbm_dat_i, pc_q, 1'b0, 1'b0);
            pc_d    = pc_q + 32'd4;
            state_d = ST_DRAIN;
          end else if (iwbm_err_i) begin
            slot_d  = make_slot(NOP_INSN, pc_q, 1'b1, 1'b0);
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (ready_i) begin
            addr_d  = pc_q;
            state_d = ST_REQ;
          end
        end
        ST_KILL: begin
          if (bus_done) begin
            addr_d  = pc_q;
            state_d = ST_REQ;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_ADDR;
      addr_q  <= RESET_ADDR;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      slot_q  <= slot_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch.sv
`default_nettype none
// ============================================================================
// tb_fetch : directed vector table plus randomized run against a pc-level model
// Revision : 1.0
// ============================================================================
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        cyc, stb;
  logic [31:0] dat;
  logic        ack, err;
  logic        br;
  logic [31:0] tgt;
  logic [31:0] ins, pco;
  logic        valid, ready;
  logic        af, mf;

  fetch #(.RESET_ADDR(32'h80000000)) dut (
    .clk_i                    (clk),
    .rst_i                    (rst),
    .iwbm_addr_o              (addr),
    .iwbm_cyc_o               (cyc),
    .iwbm_stb_o               (stb),
    .iwbm_dat_i               (dat),
    .iwbm_ack_i               (ack),
    .iwbm_err_i               (err),
    .branch_taken_i           (br),
    .branch_target_i          (tgt),
    .instruction_o            (ins),
    .pc_o                     (pco),
    .valid_o                  (valid),
    .ready_i                  (ready),
    .e_inst_access_fault_o    (af),
    .e_inst_addr_misaligned_o (mf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h13579bdf;
  endfunction

  typedef struct {
    bit          e_cyc;
    logic [31:0] e_addr;
    bit          e_val;
    logic [31:0] e_pc, e_ins;
    bit          e_af, e_mf;
    bit          ack, err;
    logic [31:0] dat;
    bit          rdy, br;
    logic [31:0] tgt;
  } vec_t;

  function automatic vec_t mk(bit ec, logic [31:0] ea, bit ev, logic [31:0] ep, logic [31:0] ei,
                              bit eaf, bit emf, bit a, bit e, logic [31:0] d, bit r, bit b,
                              logic [31:0] t);
    vec_t v;
    v.e_cyc = ec; v.e_addr = ea; v.e_val = ev; v.e_pc = ep; v.e_ins = ei;
    v.e_af = eaf; v.e_mf = emf; v.ack = a; v.err = e; v.dat = d; v.rdy = r; v.br = b; v.tgt = t;
    return v;
  endfunction

  vec_t vecs[25];

  task automatic idle_inputs();
    ack = 0; err = 0; dat = 0; ready = 0; br = 0; tgt = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_pc, last_addr, p_pc, p_ins, p_addr;
    bit          last_err, hold, busy;
    int          wait_cnt, ndel;

    // Per-cycle: outputs expected now | inputs applied for the next rising edge
    vecs[0]  = mk(0, 0,            0, 0,            0,            0, 0, 0, 0, 0,            1, 0, 0);
    vecs[1]  = mk(1, 32'h80000000, 0, 0,            0,            0, 0, 0, 0, 0,            1, 0, 0);
    vecs[2]  = mk(1, 32'h80000000, 0, 0,            0,            0, 0, 1, 0, 32'h00500093, 1, 0, 0);
    vecs[3]  = mk(0, 0,            1, 32'h80000000, 32'h00500093, 0, 0, 0, 0, 0,            1, 0, 0);
    vecs[4]  = mk(1, 32'h80000004, 0, 0,            0,            0, 0, 1, 0, 32'h11111111, 0, 0, 0);
    vecs[5]  = mk(0, 0,            1, 32'h80000004, 32'h11111111, 0, 0, 0, 0, 0,            0, 0, 0);
    vecs[6]  = mk(0, 0,            1, 32'h80000004, 32'h11111111, 0, 0, 1, 0, 32'hdeadbeef, 0, 0, 0);
    vecs[7]  = mk(0, 0,            1, 32'h80000004, 32'h11111111, 0, 0, 0, 0, 0,            0, 0, 0);
    vecs[8]  = mk(0, 0,            1, 32'h80000004, 32'h11111111, 0, 0, 0, 0, 0,            0, 0, 0);
    vecs[9]  = mk(0, 0,            1, 32'h80000004, 32'h11111111, 0, 0, 0, 0, 0,            0, 0, 0);
    vecs[10] = mk(0, 0,            1, 32'h80000004, 32'h11111111, 0, 0, 0, 0, 0,            1, 0, 0);
    vecs[11] = mk(1, 32'h80000008, 0, 0,            0,            0, 0, 0, 1, 0,            1, 0, 0);
    vecs[12] = mk(0, 0,            1, 32'h80000008, 32'h00000013, 1, 0, 0, 0, 0,            1, 0, 0);
    vecs[13] = mk(1, 32'h80000008, 0, 0,            0,            0, 0, 1, 0, 32'h22222222, 1, 0, 0);
    vecs[14] = mk(0, 0,            1, 32'h80000008, 32'h22222222, 0, 0, 0, 0, 0,            1, 1, 32'h80000102);
    vecs[15] = mk(0, 0,            1, 32'h80000102, 32'h00000013, 0, 1, 0, 0, 0,            0, 1, 32'h80000300);
    vecs[16] = mk(1, 32'h80000300, 0, 0,            0,            0, 0, 0, 0, 0,            1, 1, 32'h80000100);
    vecs[17] = mk(1, 32'h80000300, 0, 0,            0,            0, 0, 0, 0, 0,            1, 1, 32'h80000180);
    vecs[18] = mk(1, 32'h80000300, 0, 0,            0,            0, 0, 0, 0, 0,            1, 1, 32'h80000100);
    vecs[19] = mk(1, 32'h80000300, 0, 0,            0,            0, 0, 1, 0, 32'h33333333, 1, 0, 0);
    vecs[20] = mk(1, 32'h80000100, 0, 0,            0,            0, 0, 1, 0, 32'h44444444, 1, 0, 0);
    vecs[21] = mk(0, 0,            1, 32'h80000100, 32'h44444444, 0, 0, 0, 0, 0,            1, 0, 0);
    vecs[22] = mk(1, 32'h80000104, 0, 0,            0,            0, 0, 1, 0, 32'h55555555, 1, 1, 32'h80000400);
    vecs[23] = mk(1, 32'h80000400, 0, 0,            0,            0, 0, 1, 0, 32'h66666666, 1, 0, 0);
    vecs[24] = mk(0, 0,            1, 32'h80000400, 32'h66666666, 0, 0, 0, 0, 0,            1, 0, 0);

    rst = 1;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("rst_cyc", cyc, 0);
    chk("rst_stb", stb, 0);
    chk("rst_valid", valid, 0);
    chk("rst_af", af, 0);
    chk("rst_mf", mf, 0);
    chk("rst_ins", ins, 0);
    chk("rst_pc", pco, 0);
    rst = 0;

    for (int i = 0; i < 25; i++) begin
      chk($sformatf("r%0d_cyc", i), cyc, vecs[i].e_cyc);
      chk($sformatf("r%0d_stb", i), stb, vecs[i].e_cyc);
      chk($sformatf("r%0d_valid", i), valid, vecs[i].e_val);
      if (vecs[i].e_cyc) chk($sformatf("r%0d_addr", i), addr, vecs[i].e_addr);
      if (vecs[i].e_val || i == 0) begin
        chk($sformatf("r%0d_pc", i), pco, vecs[i].e_pc);
        chk($sformatf("r%0d_ins", i), ins, vecs[i].e_ins);
        chk($sformatf("r%0d_af", i), af, vecs[i].e_af);
        chk($sformatf("r%0d_mf", i), mf, vecs[i].e_mf);
      end
      ack = vecs[i].ack; err = vecs[i].err; dat = vecs[i].dat;
      ready = vecs[i].rdy; br = vecs[i].br; tgt = vecs[i].tgt;
      @(negedge clk);
    end

    // Reset landing in the middle of an open bus cycle
    idle_inputs();
    chk("pre_rst_cyc", cyc, 1);
    chk("pre_rst_addr", addr, 32'h80000404);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("async_rst_cyc", cyc, 0);
    chk("async_rst_stb", stb, 0);
    chk("async_rst_valid", valid, 0);
    @(negedge clk);
    ack = 1; dat = 32'hbadc0de5;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    ack = 0;
    chk("restart_cyc", cyc, 1);
    chk("restart_addr", addr, 32'h80000000);
    chk("restart_valid", valid, 0);
    @(negedge clk);
    chk("restart_hold_addr", addr, 32'h80000000);
    chk("restart_hold_valid", valid, 0);

    // Randomized run: delivered slots follow the architectural pc sequence
    rst = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 0;
    exp_pc = 32'h80000000; last_addr = 32'h00000001; last_err = 0;
    hold = 0; busy = 0; wait_cnt = 0; ndel = 0;
    p_pc = 0; p_ins = 0; p_addr = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold) begin
        chk("hold_valid", valid, 1);
        chk("hold_pc", pco, p_pc);
        chk("hold_ins", ins, p_ins);
      end
      if (busy) begin
        chk("busy_cyc", cyc, 1);
        chk("busy_addr", addr, p_addr);
      end
      if (cyc) chk("addr_align", {30'd0, addr[1:0]}, 0);

      ack = 0; err = 0; dat = $urandom;
      if (cyc) begin
        if (wait_cnt == 0) begin
          if ($urandom_range(0, 7) == 0) err = 1;
          else begin ack = 1; dat = mem(addr); end
        end else wait_cnt--;
      end else if ($urandom_range(0, 9) == 0) ack = 1;
      ready = ($urandom_range(0, 3) != 0);
      br = (c > 2) && ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 9))
        0:       tgt = 32'hFFFFFFF8;
        1:       tgt = 32'h80000000 + ($urandom_range(0, 63) << 2) + $urandom_range(1, 3);
        default: tgt = 32'h80000000 + ($urandom_range(0, 255) << 2);
      endcase

      if (cyc && (ack || err)) begin
        last_addr = addr; last_err = err; wait_cnt = $urandom_range(0, 3);
      end
      busy = cyc && !(ack || err);
      hold = valid && !ready && !br;
      p_pc = pco; p_ins = ins; p_addr = addr;
      if (br) begin
        exp_pc = tgt;
      end else if (valid && ready) begin
        ndel++;
        chk("deliver_pc", pco, exp_pc);
        if (exp_pc[1:0] != 2'b00) begin
          chk("deliver_mis_ins", ins, 32'h00000013);
          chk("deliver_mis_mf", mf, 1);
          chk("deliver_mis_af", af, 0);
        end else begin
          chk("deliver_fetch_addr", last_addr, exp_pc);
          chk("deliver_ins", ins, last_err ? 32'h00000013 : mem(exp_pc));
          chk("deliver_af", af, last_err);
          chk("deliver_mf", mf, 0);
          if (!last_err) exp_pc = exp_pc + 32'd4;
        end
      end
      @(negedge clk);
    end
    chk("progress", (ndel > 100) ? 1 : 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
